// File: rtl/ac_datapath.sv
// Execution datapath and sequencer for the accumulator CPU.
// Owns PC, IR, accumulator and Z/C flags and drives the external synchronous RAM.
module ac_datapath #(
  parameter int ADDR_W   = 5,
  parameter int RESET_PC = 0,
  localparam int DATA_W  = ADDR_W + 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic [2:0]        op_o,
  input  logic              jmp_i,
  input  logic              wr_i,
  input  logic              wm_i,
  input  logic              alu_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [DATA_W-1:0] acc_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              z_o,
  output logic              c_o,
  output logic              busy_o,
  output logic              halt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_FETCH_W,
    S_EXEC,
    S_MEM_W,
    S_HALT
  } state_t;

  localparam logic [2:0] OP_LDA = 3'b010;
  localparam logic [2:0] OP_JMP = 3'b100;
  localparam logic [2:0] OP_JZ  = 3'b101;
  localparam logic [2:0] OP_JC  = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  state_t              state;
  state_t              next_state;
  logic [ADDR_W-1:0]   pc;
  logic [DATA_W-1:0]   ir;
  logic [DATA_W-1:0]   acc;
  logic                z_flag;
  logic                c_flag;
  logic                alu_sub;
  logic                jump_taken;
  logic [2:0]          op;
  logic [ADDR_W-1:0]   operand;
  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   diff;

  assign op      = ir[DATA_W-1:ADDR_W];
  assign operand = ir[ADDR_W-1:0];
  assign sum     = {1'b0, acc} + {1'b0, mem_rdata_i};
  assign diff    = acc - mem_rdata_i;

  // Strobes are forced low while reset is asserted so an in-flight STA never writes.
  always_comb begin
    next_state = state;
    mem_addr_o = pc;
    mem_rd_o   = 1'b0;
    mem_we_o   = 1'b0;
    jump_taken = 1'b0;
    case (state)
      S_IDLE, S_HALT: begin
        if (start_i) next_state = S_FETCH;
      end
      S_FETCH: begin
        mem_rd_o   = 1'b1;
        next_state = S_FETCH_W;
      end
      S_FETCH_W: next_state = S_EXEC;
      S_EXEC: begin
        if (jmp_i) begin
          jump_taken = (op == OP_JMP) || ((op == OP_JZ) && z_flag) || ((op == OP_JC) && c_flag);
          next_state = S_FETCH;
        end else if (wm_i) begin
          mem_addr_o = operand;
          mem_we_o   = 1'b1;
          next_state = S_FETCH;
        end else if (wr_i) begin
          mem_addr_o = operand;
          mem_rd_o   = 1'b1;
          next_state = S_MEM_W;
        end else if (op == OP_HLT) begin
          next_state = S_HALT;
        end else begin
          next_state = S_FETCH;
        end
      end
      S_MEM_W: next_state = S_FETCH;
      default: next_state = S_IDLE;
    endcase
    if (rst_i) begin
      mem_rd_o = 1'b0;
      mem_we_o = 1'b0;
    end
  end

  // alu_i is captured in EXEC so the ALU operation does not depend on the control unit in MEM_W.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      pc      <= ADDR_W'(RESET_PC);
      ir      <= '0;
      acc     <= '0;
      z_flag  <= 1'b0;
      c_flag  <= 1'b0;
      alu_sub <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        S_FETCH_W: begin
          ir <= mem_rdata_i;
          pc <= pc + 1'b1;
        end
        S_EXEC: begin
          alu_sub <= alu_i;
          if (jump_taken) pc <= operand;
        end
        S_MEM_W: begin
          if (op == OP_LDA) begin
            acc    <= mem_rdata_i;
            z_flag <= (mem_rdata_i == '0);
          end else if (alu_sub) begin
            acc    <= diff;
            c_flag <= (acc < mem_rdata_i);
            z_flag <= (diff == '0);
          end else begin
            acc    <= sum[DATA_W-1:0];
            c_flag <= sum[DATA_W];
            z_flag <= (sum[DATA_W-1:0] == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign op_o        = op;
  assign mem_wdata_o = acc;
  assign acc_o       = acc;
  assign pc_o        = pc;
  assign z_o         = z_flag;
  assign c_o         = c_flag;
  assign busy_o      = (state == S_FETCH) || (state == S_FETCH_W) || (state == S_EXEC) || (state == S_MEM_W);
  assign halt_o      = (state == S_HALT);

endmodule
